com_byte_streamer: RTL

//  Downstream sink for processor result reads while COMFlag is high.

---
 rtl/com_stream_pkg.sv | 7 +
 rtl/com_word_fifo.sv | 53 +++++
 rtl/com_byte_streamer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/com_stream_pkg.sv
// com_stream_pkg: shared types and constants for the COM byte streamer
// Contents: stream_state_t FSM encoding, FRAME_MARKER byte, word_t data word.
package com_stream_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} stream_state_t;
  localparam logic [7:0] FRAME_MARKER = 8'hA5;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/com_word_fifo.sv
// com_word_fifo: DEPTH-entry word FIFO with registered full/empty flags
// Ports: clk, reset (sync, active-high), push/din write side, pop/dout read side
//        (dout shows the head word), full, empty.
// A push while full is accepted only when a pop shares the cycle; a pop while empty is ignored.
module com_word_fifo
  import com_stream_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output word_t dout,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  word_t       r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_full;
  logic        r_empty;
  logic        w_push;
  logic        w_pop;
  logic [AW:0] w_wr_nxt;
  logic [AW:0] w_rd_nxt;
  assign w_pop    = pop & ~r_empty;
  assign w_push   = push & (~r_full | w_pop);
  assign w_wr_nxt = r_wr + {{AW{1'b0}}, w_push};
  assign w_rd_nxt = r_rd + {{AW{1'b0}}, w_pop};
  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_full  <= (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
      r_empty <= w_wr_nxt == w_rd_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= din;
  end
  assign dout  = r_mem[r_rd[AW-1:0]];
  assign full  = r_full;
  assign empty = r_empty;
endmodule

// File: rtl/com_byte_streamer.sv
// com_byte_streamer: buffers COM-window load words and serialises them as strobed bytes
// Ports: clk, reset (sync, active-high); COMFlag & MemtoReg qualify capture of ReadData;
//        ReadDataOut byte with strobe clk_out; busy, stall (FIFO full), sticky overflow.
// Build option: FRAME_MARKER_EN prefixes every word with FRAME_MARKER (8'hA5).
module com_byte_streamer
  import com_stream_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int STROBE_CYCLES  = 4,
  parameter int HOLD_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        COMFlag,
  input  logic        MemtoReg,
  input  logic [31:0] ReadData,
  output logic [7:0]  ReadDataOut,
  output logic        clk_out,
  output logic        busy,
  output logic        stall,
  output logic        overflow
);
`ifdef FRAME_MARKER_EN
  localparam int NB = BYTES_PER_WORD + 1;
`else
  localparam int NB = BYTES_PER_WORD;
`endif
  stream_state_t r_state;
  word_t         r_shift;
  logic [2:0]    r_idx;
  logic [15:0]   r_cnt;
  logic [7:0]    r_data;
  logic          r_strobe;
  logic          r_ovf;
  logic          w_capture;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_last_byte;
  logic          w_hold_done;
  word_t         w_dout;
  assign w_capture   = COMFlag & MemtoReg;
  assign w_last_byte = r_idx == 3'(NB - 1);
  assign w_hold_done = (r_state == HOLD) && (r_cnt == 16'(HOLD_CYCLES - 1));
  // Head word is taken when idle, or when the last byte of the current word finishes its hold.
  assign w_pop       = ~w_empty & ((r_state == IDLE) | (w_hold_done & w_last_byte));
  com_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (w_capture),
    .pop  (w_pop),
    .din  (ReadData),
    .dout (w_dout),
    .full (w_full),
    .empty(w_empty)
  );
  // The byte placed on ReadDataOut is shifted out of r_shift at the same time,
  // so r_shift[7:0] is always the next data byte still to be presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_strobe <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_capture & w_full & ~w_pop) r_ovf <= 1'b1;
      case (r_state)
        IDLE: begin
          if (~w_empty) begin
            r_shift <= w_dout;
            r_idx   <= '0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
`ifdef FRAME_MARKER_EN
          r_data  <= FRAME_MARKER;
`else
          r_data  <= r_shift[7:0];
          r_shift <= r_shift >> 8;
`endif
          r_cnt   <= '0;
          r_state <= SETUP;
        end
        SETUP: begin
          if (r_cnt == 16'(SETUP_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_strobe <= 1'b1;
            r_state  <= STROBE;
          end else r_cnt <= r_cnt + 16'd1;
        end
        STROBE: begin
          if (r_cnt == 16'(STROBE_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_state  <= HOLD;
          end else r_cnt <= r_cnt + 16'd1;
        end
        HOLD: begin
          if (w_hold_done) begin
            r_cnt <= '0;
            if (!w_last_byte) begin
              r_data  <= r_shift[7:0];
              r_shift <= r_shift >> 8;
              r_idx   <= r_idx + 3'd1;
              r_state <= SETUP;
            end else if (~w_empty) begin
              r_shift <= w_dout;
              r_idx   <= '0;
              r_state <= LOAD;
            end else r_state <= IDLE;
          end else r_cnt <= r_cnt + 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ReadDataOut = r_data;
  assign clk_out     = r_strobe;
  assign busy        = ~w_empty | (r_state != IDLE);
  assign stall       = w_full;
  assign overflow    = r_ovf;
endmodule
